// File: rtl/shift_issue_sched_pkg.sv
// riftcore_pkg: shared types and constants for the shift issue scheduler.
// Contents:
//   RNDEPTH/RNBIT/TAG_W/PHY  rename geometry (physical tag = 5 arch bits + RNBIT copy bits)
//   INFO_W                   width of the packed shift_info_t
//   PHY_ZERO                 physical tag of x0, which is always readable
//   shift_info_t             one dispatched shift op
//   src_ready()              RAW check of one source tag against the write-back scoreboard
package riftcore_pkg;

  localparam int RNDEPTH = 4;
  localparam int RNBIT   = $clog2(RNDEPTH);
  localparam int TAG_W   = 5 + RNBIT;
  localparam int PHY     = 32 * RNDEPTH;
  localparam int INFO_W  = 11 + 3 * TAG_W;

  localparam logic [TAG_W-1:0] PHY_ZERO = '0;

  typedef struct packed {
    logic             fun_sll;
    logic             fun_srl;
    logic             fun_sra;
    logic             is32;
    logic             isImm;
    logic [5:0]       shamt;
    logic [TAG_W-1:0] rd0;
    logic [TAG_W-1:0] rs1;
    logic [TAG_W-1:0] rs2;
  } shift_info_t;

  // x0 never waits on write-back, so tag zero counts as ready regardless of the scoreboard.
  function automatic logic src_ready(input logic [PHY-1:0] wb, input logic [TAG_W-1:0] tag);
    return wb[tag] | (tag == PHY_ZERO);
  endfunction

endpackage

// File: rtl/shift_issue_sched_if.sv
// shift_issue_sched_if: valid/ready handshake carrying one shift_info_t.
// Signals:
//   vaild  producer offers info this cycle
//   ready  consumer accepts info this cycle
//   info   the shift op
// Modports: master drives vaild/info, slave drives ready.
interface shift_issue_sched_if;
  import riftcore_pkg::*;

  logic        vaild;
  logic        ready;
  shift_info_t info;

  modport master (output vaild, output info, input ready);
  modport slave  (input vaild, input info, output ready);
endinterface

// File: rtl/shift_issue_sched_lzc.sv
// lzc: finds the lowest set bit of a vector.
// Ports:
//   in_i     request vector
//   cnt_o    index of the lowest set bit (0 when none are set)
//   empty_o  no bit of in_i is set
module lzc #(
  parameter int  WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = IDX_W'(i);
    end
    empty_o = ~|in_i;
  end

endmodule

// File: rtl/shift_issue_sched.sv
// shift_issue_sched: issue queue between dispatch and the shift execute unit.
// Holds up to DEPTH shift ops, checks their sources against the write-back
// scoreboard every cycle and offers the lowest-index ready entry to execute.
// Ports:
//   CLK, RST     clock and asynchronous active-high reset
//   flush        drops every entry at the next edge, blocks push and pop this cycle
//   dispat       slave handshake from dispatch
//   wbBuf_qout   scoreboard, bit p set once physical reg p is written back
//   execute      master handshake towards the shift unit
//   issue_cnt    number of occupied entries (registered)
module shift_issue_sched
  import riftcore_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  shift_issue_sched_if.slave     dispat,
  input  logic [PHY-1:0]         wbBuf_qout,
  shift_issue_sched_if.master    execute,
  output logic [$clog2(DEPTH):0] issue_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  shift_info_t      info_q [DEPTH];
  shift_info_t      info_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] free_vec;
  logic [IDX_W-1:0] free_idx, sel_idx, push_idx;
  logic             full, none_ready;
  logic             pop, push, accept_rdy;

  // An entry is ready when both sources are written back; immediates skip rs2.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i]
               & src_ready(wbBuf_qout, info_q[i].rs1)
               & (info_q[i].isImm | src_ready(wbBuf_qout, info_q[i].rs2));
    end
    free_vec = ~valid_q;
  end

  lzc #(.WIDTH(DEPTH)) u_free_lzc (
    .in_i    (free_vec),
    .cnt_o   (free_idx),
    .empty_o (full)
  );

  lzc #(.WIDTH(DEPTH)) u_sel_lzc (
    .in_i    (ready),
    .cnt_o   (sel_idx),
    .empty_o (none_ready)
  );

  // Handshake outputs. When full, the only slot a push can use is the one
  // being popped, which is the selected entry.
  always_comb begin
    execute.vaild = ~none_ready;
    execute.info  = none_ready ? '0 : info_q[sel_idx];
    pop           = ~none_ready & execute.ready & ~flush;
    accept_rdy    = ~flush & (~full | pop);
    dispat.ready  = accept_rdy;
    push          = dispat.vaild & accept_rdy;
    push_idx      = full ? sel_idx : free_idx;
  end

  // Next entry state. Clearing before setting lets a full-queue push reuse the popped slot.
  always_comb begin
    valid_d = valid_q;
    info_d  = info_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (pop) valid_d[sel_idx] = 1'b0;
      if (push) begin
        valid_d[push_idx] = 1'b1;
        info_d[push_idx]  = dispat.info;
      end
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  // Entry storage and occupancy count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) info_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
    end
  end

  assign issue_cnt = cnt_q;

endmodule
